// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// common_pkg / muldiv_ctrl
//
// Execute-stage sequencer for the shared multi-cycle multiply/divide unit.
// One M-extension request is accepted from EX at a time. It is either resolved
// on an architectural fast path (divide by zero, signed overflow, multiply by
// zero) or issued to the unit, after which the sequencer stalls the pipeline
// until the unit reports completion. Exactly one tagged response is produced
// per surviving request. Operations killed by a flush are drained from the
// unit before the next one is issued.
//
// Ports
//   clk, reset_n            clock / async active-low reset
//   req_valid, req_op,      request from EX; held stable while stall_o=1
//   req_rs1, req_rs2,
//   req_tag
//   flush                   kill the current EX instruction and any op in flight
//   stall_o                 freeze IF/ID/EX
//   rsp_valid, rsp_result,  one-cycle tagged result strobe
//   rsp_tag
//   md_start, md_op,        start pulse, op and operands to the unit
//   md_operand1/2
//   md_result, md_ready     unit result (valid while md_ready=1) and done/idle
// -----------------------------------------------------------------------------
package common_pkg;
   localparam int XLEN_WIDTH = 32;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
   } alu_op_type;
endpackage

module muldiv_ctrl
   import common_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   input  alu_op_type            req_op,
   input  logic [XLEN_WIDTH-1:0] req_rs1,
   input  logic [XLEN_WIDTH-1:0] req_rs2,
   input  logic [TAG_W-1:0]      req_tag,
   input  logic                  flush,
   output logic                  stall_o,
   output logic                  rsp_valid,
   output logic [XLEN_WIDTH-1:0] rsp_result,
   output logic [TAG_W-1:0]      rsp_tag,
   output logic                  md_start,
   output alu_op_type            md_op,
   output logic [XLEN_WIDTH-1:0] md_operand1,
   output logic [XLEN_WIDTH-1:0] md_operand2,
   input  logic [XLEN_WIDTH-1:0] md_result,
   input  logic                  md_ready
);

   localparam logic [XLEN_WIDTH-1:0] MIN_NEG = {1'b1, {(XLEN_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE,
      S_DRAIN
   } state_e;

   state_e                  state_q, state_d;
   alu_op_type              op_q, op_d;
   logic [XLEN_WIDTH-1:0]   rs1_q, rs1_d;
   logic [XLEN_WIDTH-1:0]   rs2_q, rs2_d;
   logic [TAG_W-1:0]        tag_q, tag_d;
   logic [XLEN_WIDTH-1:0]   rsp_result_q, rsp_result_d;
   logic [TAG_W-1:0]        rsp_tag_q, rsp_tag_d;

   logic                    legal_op;
   logic                    fast_hit;
   logic [XLEN_WIDTH-1:0]   fast_res;
   logic                    rs1_zero, rs2_zero, div_ovf;
   logic                    accept;

   // -------------------------------------------------------------------------
   // Request decode
   // -------------------------------------------------------------------------
   always_comb begin
      legal_op = 1'b0;
      case (req_op)
         ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: legal_op = 1'b1;
         default: legal_op = 1'b0;
      endcase
   end

   assign rs1_zero = (req_rs1 == '0);
   assign rs2_zero = (req_rs2 == '0);
   assign div_ovf  = (req_rs1 == MIN_NEG) && (req_rs2 == '1);

   // Results the ISA fixes without needing the unit. Divide-by-zero is checked
   // before overflow so DIV MIN_NEG/0 still returns all-ones.
   always_comb begin
      fast_hit = 1'b0;
      fast_res = '0;
      case (req_op)
         ALU_DIV: begin
            if (rs2_zero) begin
               fast_hit = 1'b1;
               fast_res = '1;
            end else if (div_ovf) begin
               fast_hit = 1'b1;
               fast_res = MIN_NEG;
            end
         end
         ALU_DIVU: begin
            if (rs2_zero) begin
               fast_hit = 1'b1;
               fast_res = '1;
            end
         end
         ALU_REM: begin
            if (rs2_zero) begin
               fast_hit = 1'b1;
               fast_res = req_rs1;
            end else if (div_ovf) begin
               fast_hit = 1'b1;
               fast_res = '0;
            end
         end
         ALU_REMU: begin
            if (rs2_zero) begin
               fast_hit = 1'b1;
               fast_res = req_rs1;
            end
         end
         ALU_MUL: begin
            if (rs1_zero || rs2_zero) begin
               fast_hit = 1'b1;
               fast_res = '0;
            end
         end
         default: begin
            fast_hit = 1'b0;
            fast_res = '0;
         end
      endcase
   end

   assign accept = (state_q == S_IDLE) && req_valid && legal_op && !flush;

   // -------------------------------------------------------------------------
   // Next state and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      tag_d        = tag_q;
      rsp_result_d = rsp_result_q;
      rsp_tag_d    = rsp_tag_q;
      stall_o      = 1'b0;
      rsp_valid    = 1'b0;
      md_start     = 1'b0;
      md_op        = op_q;
      md_operand1  = rs1_q;
      md_operand2  = rs2_q;

      case (state_q)
         S_IDLE: begin
            // The unit sees the live request so md_start and its operands
            // arrive in the same cycle.
            md_op       = req_op;
            md_operand1 = req_rs1;
            md_operand2 = req_rs2;
            if (accept) begin
               stall_o = 1'b1;
               tag_d   = req_tag;
               if (fast_hit) begin
                  rsp_result_d = fast_res;
                  rsp_tag_d    = req_tag;
                  state_d      = S_DONE;
               end else begin
                  md_start = 1'b1;
                  op_d     = req_op;
                  rs1_d    = req_rs1;
                  rs2_d    = req_rs2;
                  state_d  = S_BUSY;
               end
            end
         end

         S_BUSY: begin
            stall_o = 1'b1;
            if (flush) begin
               // A unit that finishes in the flush cycle needs no draining.
               state_d = md_ready ? S_IDLE : S_DRAIN;
            end else if (md_ready) begin
               rsp_result_d = md_result;
               rsp_tag_d    = tag_q;
               state_d      = S_DONE;
            end
         end

         S_DONE: begin
            // The request still on the bus this cycle is the one just answered;
            // it is never re-accepted because acceptance only happens in IDLE.
            rsp_valid = !flush;
            state_d   = S_IDLE;
         end

         S_DRAIN: begin
            // Hold back a younger request until the killed op leaves the unit.
            stall_o = req_valid && legal_op;
            if (md_ready) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         op_q         <= ALU_ADD;
         rs1_q        <= '0;
         rs2_q        <= '0;
         tag_q        <= '0;
         rsp_result_q <= '0;
         rsp_tag_q    <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         tag_q        <= tag_d;
         rsp_result_q <= rsp_result_d;
         rsp_tag_q    <= rsp_tag_d;
      end
   end

   assign rsp_result = rsp_result_q;
   assign rsp_tag    = rsp_tag_q;

endmodule
